// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the common data width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_rx_shift_reg.sv
// Right-shifting receive register; the first (LSB) bit ends up at the bottom after a full word.
module rx_shift_reg
    import uart_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift,
    input  logic                   rx_bit,
    output logic [UART_DATA_W-1:0] data
);

    logic [UART_DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (shift) begin
            r_data <= {rx_bit, r_data[UART_DATA_W-1:1]};
        end
    end

    assign data = r_data;

endmodule

// File: rtl/uart_rx.sv
// Mid-bit sampling UART receiver with framing check.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE_HZ     = 3,
    parameter int BAUD_RATE_HZ      = 1,
    parameter int BITS_PER_TRANSFER = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    output logic                   busy,
    output logic                   frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int CLOCKS_PER_BAUD = CLOCK_RATE_HZ / BAUD_RATE_HZ;
    localparam int BAUD_W          = $clog2(CLOCKS_PER_BAUD);
    localparam int ALIGN_SHIFT     = UART_DATA_W - BITS_PER_TRANSFER;

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [3:0]        LAST_BIT  = 4'(BITS_PER_TRANSFER - 1);

    uart_rx_state_t         r_state;
    logic [BAUD_W-1:0]      r_baud_cnt;
    logic [3:0]             r_bit_cnt;
    logic [1:0]             r_sync;
    logic                   r_last;
    logic [UART_DATA_W-1:0] r_data;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_frame_err;

    logic                   w_rx_s;
    logic                   w_fall;
    logic                   w_mid;
    logic                   w_shift;
    logic [UART_DATA_W-1:0] w_shift_data;
    logic [UART_DATA_W-1:0] w_aligned;

    assign w_rx_s  = r_sync[1];
    assign w_fall  = !w_rx_s && r_last;
    assign w_mid   = (r_baud_cnt == FULL_LAST);
    assign w_shift = (r_state == DATA) && w_mid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_last <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_last <= w_rx_s;
        end
    end

    rx_shift_reg u_shift (
        .clk    (clk),
        .rst    (rst),
        .shift  (w_shift),
        .rx_bit (w_rx_s),
        .data   (w_shift_data)
    );

    // Short words sit in the top of the shift register; move them to the bottom.
    genvar gi;
    generate
        for (gi = 0; gi < UART_DATA_W; gi++) begin : g_align
            if (gi < BITS_PER_TRANSFER) begin : g_bit
                assign w_aligned[gi] = w_shift_data[gi + ALIGN_SHIFT];
            end else begin : g_zero
                assign w_aligned[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef UART_RX_PARITY_EN
    logic r_parity_bit;
    logic r_parity_err;
    logic w_parity_ok;

    assign w_parity_ok = !((^w_aligned) ^ r_parity_bit);
    assign parity_err  = r_parity_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (w_fall) begin
                        r_state    <= START;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (r_baud_cnt == HALF_LAST) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_mid) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_mid) begin
                        r_parity_bit <= w_rx_s;
                        r_state      <= STOP;
                        r_baud_cnt   <= '0;
                        r_bit_cnt    <= '0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Re-arm at mid-stop so a following start edge is never missed.
                    if (w_mid) begin
                        r_state     <= IDLE;
                        r_baud_cnt  <= '0;
                        r_bit_cnt   <= '0;
                        r_busy      <= 1'b0;
                        r_data      <= w_aligned;
                        r_frame_err <= !w_rx_s;
`ifdef UART_RX_PARITY_EN
                        r_valid      <= w_rx_s && w_parity_ok;
                        r_parity_err <= !w_parity_ok;
`else
                        r_valid <= w_rx_s;
`endif
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-accurately and predicted from the frame rules.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       w_parity_err;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         valid_cycles[$];
    int         cycle = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic       prev_busy = 1'b0;
    logic       busy_seen = 1'b0;
    logic [7:0] last_d = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    uart_rx #(
        .CLOCK_RATE_HZ     (16),
        .BAUD_RATE_HZ      (1),
        .BITS_PER_TRANSFER (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(w_parity_err)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign w_parity_err = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Reference: stop=0 gives frame_err, odd total parity gives parity_err, valid only if neither.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        exp_t e;
        e.d  = d;
        e.fe = !stop_b;
        e.pe = PAR_EN && ((^d) ^ par_b);
        e.v  = stop_b && !e.pe;
        exp_q.push_back(e);
        last_d = d;
        $display("frame d=%02h stop=%0b par=%0b -> v=%0b fe=%0b pe=%0b", d, stop_b, par_b, e.v, e.fe, e.pe);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_b);
        drive_bit(stop_b);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && (valid || frame_err || w_parity_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {valid, frame_err, w_parity_err}, 3'b000);
            end else begin
                mon_e = exp_q.pop_front();
                check("valid", valid, mon_e.v);
                check("frame_err", frame_err, mon_e.fe);
                check("parity_err", w_parity_err, mon_e.pe);
                check("data", data, mon_e.d);
                check("busy_at_strobe", busy, 1'b0);
                check("busy_before_strobe", prev_busy, 1'b1);
            end
            if (valid) valid_cycles.push_back(cycle);
        end
        if (busy) busy_seen = 1'b1;
        prev_busy = busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n0;
        logic [7:0] d;
        logic       s;
        logic       p;
        logic       prev_bad;
        int         gap;

        #1;
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(20);

        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(32);
        wait_drain();

        n0 = valid_cycles.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(32);
        wait_drain();
        check("b2b_count", valid_cycles.size() - n0, 2);
        if (valid_cycles.size() - n0 == 2)
            check("b2b_spacing", valid_cycles[n0+1] - valid_cycles[n0], CPB * (10 + 32'(PAR_EN)));

        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check("false_start_busy_seen", busy_seen, 1'b1);
        check("false_start_busy_now", busy, 1'b0);
        check("false_start_no_strobe", exp_q.size(), 0);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        idle(32);
        wait_drain();

        send_frame(8'h81, 1'b0, ^8'h81);
        idle(32);
        wait_drain();
        check("data_hold_after_ferr", data, 8'h81);

        $display("frame d=55 aborted by rst at bit 4");
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i));
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_data", data, 8'h00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_valid", valid, 1'b0);
        check("rst_mid_frame_err", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(200);
        check("rst_no_strobe", exp_q.size(), 0);
        send_frame(8'h96, 1'b1, ^8'h96);
        idle(32);
        wait_drain();

        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b0);
            idle(32);
            send_frame(8'h07, 1'b1, 1'b1);
            idle(32);
            wait_drain();
        end

        prev_bad = 1'b0;
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom_range(0, 255));
            s   = ($urandom_range(0, 3) != 0);
            p   = (^d) ^ ($urandom_range(0, 3) == 0);
            gap = prev_bad ? CPB + $urandom_range(0, 8) : $urandom_range(0, 20);
            idle(gap);
            send_frame(d, s, p);
            prev_bad = !s;
        end
        idle(40);
        wait_drain();
        check("data_hold_final", data, last_d);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
